// File: rtl/trdb_packet_sched.sv
// Trace-encoder packet scheduler: picks the packet format per retired instruction, keeps the
// live branch map and resync counter, and queues requests toward the packet emitter.
package trdb_pkg;
  typedef enum logic [1:0] {
    F_BRANCH_DIFF = 2'h0,
    F_BRANCH_FULL = 2'h1,
    F_ADDR_ONLY   = 2'h2,
    F_SYNC        = 2'h3
  } trdb_format_t;

  typedef enum logic [1:0] {
    SF_START     = 2'h0,
    SF_EXCEPTION = 2'h1,
    SF_CONTEXT   = 2'h2,
    SF_UNDEF     = 2'h3
  } trdb_subformat_t;
endpackage

module trdb_packet_sched
  import trdb_pkg::*;
#(
  parameter int BRANCH_MAP_LEN = 31,
  parameter int FIFO_DEPTH     = 4,
  parameter int RESYNC_MAX     = 256,
  localparam int CW = $clog2(BRANCH_MAP_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic                      branch_i,
  input  logic                      branch_taken_i,
  input  logic                      lc_exception_i,
  input  logic                      lc_u_discontinuity_i,
  input  logic                      tc_first_qualified_i,
  input  logic                      tc_unhalted_i,
  input  logic                      tc_privchange_i,
  input  logic                      tc_context_change_i,
  input  logic                      nc_halt_i,
  input  logic                      nc_exception_i,
  input  logic                      nc_privchange_i,
  input  logic                      nc_unqualified_i,
  output logic                      packet_valid_o,
  input  logic                      packet_ready_i,
  output trdb_format_t              packet_format_o,
  output trdb_subformat_t           packet_subformat_o,
  output logic [CW-1:0]             branch_cnt_o,
  output logic [BRANCH_MAP_LEN-1:0] branch_map_o,
  output logic                      overflow_o,
  output logic                      resync_pending_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(RESYNC_MAX);

  typedef struct packed {
    trdb_format_t              fmt;
    trdb_subformat_t           sub;
    logic [CW-1:0]             cnt;
    logic [BRANCH_MAP_LEN-1:0] map;
  } entry_t;

  entry_t                    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]               fifo_cnt_q, fifo_cnt_d;
  logic [BRANCH_MAP_LEN-1:0] map_q, map_d, map_eff;
  logic [CW-1:0]             cnt_q, cnt_d, cnt_eff;
  logic [RW-1:0]             rs_cnt_q, rs_cnt_d;
  logic                      pend_q, pend_d, ovf_q, ovf_d;
  logic                      req, push, pop, drop, fifo_full, is_empty, is_full, nc_any;
  trdb_format_t              req_fmt;
  trdb_subformat_t           req_sub;
  entry_t                    head;

  always_comb begin
    map_eff  = map_q | (BRANCH_MAP_LEN'(branch_i & ~branch_taken_i) << cnt_q);
    cnt_eff  = cnt_q + CW'(branch_i);
    is_empty = (cnt_eff == '0);
    is_full  = (cnt_eff == CW'(BRANCH_MAP_LEN));
    nc_any   = nc_halt_i | nc_exception_i | nc_privchange_i | nc_unqualified_i;
    req      = 1'b0;
    req_fmt  = F_BRANCH_DIFF;
    req_sub  = SF_START;
    if (valid_i) begin
      if (lc_exception_i) begin
        req = 1'b1; req_fmt = F_SYNC; req_sub = SF_EXCEPTION;
      end else if (tc_first_qualified_i | tc_unhalted_i | tc_privchange_i | pend_q) begin
        req = 1'b1; req_fmt = F_SYNC; req_sub = SF_START;
      end else if (lc_u_discontinuity_i | nc_any) begin
        req = 1'b1; req_fmt = is_empty ? F_ADDR_ONLY : F_BRANCH_FULL; req_sub = SF_UNDEF;
      end else if (is_full) begin
        req = 1'b1; req_fmt = F_BRANCH_FULL; req_sub = SF_UNDEF;
      end else if (tc_context_change_i) begin
        req = 1'b1; req_fmt = F_SYNC; req_sub = SF_CONTEXT;
      end
    end
  end

  // A pop frees a slot in the same cycle, so push-while-full with a pop is not a drop.
  assign fifo_full = (fifo_cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop       = packet_valid_o & packet_ready_i;
  assign push      = req & (~fifo_full | pop);
  assign drop      = req & fifo_full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    fifo_cnt_d = fifo_cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    map_d      = map_q;
    cnt_d      = cnt_q;
    rs_cnt_d   = rs_cnt_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q | drop;
    if (valid_i) begin
      map_d = req ? '0 : map_eff;
      cnt_d = req ? '0 : cnt_eff;
      if (rs_cnt_q == RW'(RESYNC_MAX - 1)) pend_d = 1'b1;
      else rs_cnt_d = rs_cnt_q + RW'(1);
    end
    if (req && req_fmt == F_SYNC) begin
      rs_cnt_d = '0;
      if (req_sub == SF_START) pend_d = 1'b0;
    end
    if (drop) pend_d = 1'b1;
    if (flush_i) begin
      wr_ptr_d = '0; rd_ptr_d = '0; fifo_cnt_d = '0;
      map_d = '0; cnt_d = '0; rs_cnt_d = '0; pend_d = 1'b0; ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      map_q      <= '0;
      cnt_q      <= '0;
      rs_cnt_q   <= '0;
      pend_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      map_q      <= map_d;
      cnt_q      <= cnt_d;
      rs_cnt_q   <= rs_cnt_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: every read is masked by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) fifo_mem[wr_ptr_q] <= '{fmt: req_fmt, sub: req_sub, cnt: cnt_eff, map: map_eff};
  end

  assign head               = fifo_mem[rd_ptr_q];
  assign packet_valid_o     = (fifo_cnt_q != '0);
  assign packet_format_o    = packet_valid_o ? head.fmt : F_BRANCH_DIFF;
  assign packet_subformat_o = packet_valid_o ? head.sub : SF_START;
  assign branch_cnt_o       = packet_valid_o ? head.cnt : '0;
  assign branch_map_o       = packet_valid_o ? head.map : '0;
  assign overflow_o         = ovf_q;
  assign resync_pending_o   = pend_q;
endmodule

// File: tb/tb_trdb_packet_sched.sv
// Directed bench for trdb_packet_sched; a second instance with a short resync period
// shares the stimulus and is only checked during the resync scenario.
module tb_trdb_packet_sched;
  import trdb_pkg::*;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ready = 1'b0;
  logic valid, br, tk, lc_exc, lc_u, tc_first, tc_unh, tc_priv, tc_ctx;
  logic nc_halt, nc_exc, nc_priv, nc_unq;

  logic            pv, ovf, pend;
  trdb_format_t    fmt;
  trdb_subformat_t sub;
  logic [4:0]      cnt;
  logic [30:0]     map;

  logic            pv_r, ovf_r, pend_r;
  trdb_format_t    fmt_r;
  trdb_subformat_t sub_r;
  logic [4:0]      cnt_r;
  logic [30:0]     map_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trdb_packet_sched u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .branch_i(br),
    .branch_taken_i(tk), .lc_exception_i(lc_exc), .lc_u_discontinuity_i(lc_u),
    .tc_first_qualified_i(tc_first), .tc_unhalted_i(tc_unh), .tc_privchange_i(tc_priv),
    .tc_context_change_i(tc_ctx), .nc_halt_i(nc_halt), .nc_exception_i(nc_exc),
    .nc_privchange_i(nc_priv), .nc_unqualified_i(nc_unq), .packet_valid_o(pv),
    .packet_ready_i(ready), .packet_format_o(fmt), .packet_subformat_o(sub),
    .branch_cnt_o(cnt), .branch_map_o(map), .overflow_o(ovf), .resync_pending_o(pend)
  );

  trdb_packet_sched #(.RESYNC_MAX(8)) u_dut_rs (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .branch_i(br),
    .branch_taken_i(tk), .lc_exception_i(lc_exc), .lc_u_discontinuity_i(lc_u),
    .tc_first_qualified_i(tc_first), .tc_unhalted_i(tc_unh), .tc_privchange_i(tc_priv),
    .tc_context_change_i(tc_ctx), .nc_halt_i(nc_halt), .nc_exception_i(nc_exc),
    .nc_privchange_i(nc_priv), .nc_unqualified_i(nc_unq), .packet_valid_o(pv_r),
    .packet_ready_i(ready), .packet_format_o(fmt_r), .packet_subformat_o(sub_r),
    .branch_cnt_o(cnt_r), .branch_map_o(map_r), .overflow_o(ovf_r), .resync_pending_o(pend_r)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clr_in();
    valid = 0; br = 0; tk = 0; lc_exc = 0; lc_u = 0; tc_first = 0; tc_unh = 0;
    tc_priv = 0; tc_ctx = 0; nc_halt = 0; nc_exc = 0; nc_priv = 0; nc_unq = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic b, input logic t, input logic u);
    valid = 1; br = b; tk = t; lc_u = u;
    cycle();
    clr_in();
  endtask

  task automatic pop();
    ready = 1;
    cycle();
    ready = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    cycle();
    flush = 0;
  endtask

  initial begin
    clr_in();
    repeat (2) cycle();
    check_eq("rst_valid", pv, 0);
    check_eq("rst_fmt", fmt, 0);
    check_eq("rst_cnt", cnt, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_pend", pend, 0);
    rst = 0;
    cycle();

    // T, N, T then a non-branch uninferable discontinuity
    instr(1, 1, 0); instr(1, 0, 0); instr(1, 1, 0);
    check_eq("tnt_no_req", pv, 0);
    instr(0, 0, 1);
    check_eq("tnt_valid", pv, 1);
    check_eq("tnt_fmt", fmt, F_BRANCH_FULL);
    check_eq("tnt_sub", sub, SF_UNDEF);
    check_eq("tnt_cnt", cnt, 3);
    check_eq("tnt_map", map, 31'b010);
    pop();
    check_eq("tnt_popped", pv, 0);

    // 31 branches, even ones taken: not-taken bits at odd positions
    for (int i = 0; i < 30; i++) instr(1, (i % 2) == 0, 0);
    check_eq("map30_no_req", pv, 0);
    instr(1, 1, 0);
    check_eq("full_valid", pv, 1);
    check_eq("full_fmt", fmt, F_BRANCH_FULL);
    check_eq("full_cnt", cnt, 31);
    check_eq("full_map", map, 31'h2AAA_AAAA);
    instr(0, 0, 1);
    pop();
    check_eq("addr_valid", pv, 1);
    check_eq("addr_fmt", fmt, F_ADDR_ONLY);
    check_eq("addr_sub", sub, SF_UNDEF);
    check_eq("addr_cnt", cnt, 0);
    check_eq("addr_map", map, 0);
    pop();

    // Exception wins over context change and next-cycle halt
    do_flush();
    valid = 1; lc_exc = 1; tc_ctx = 1; nc_halt = 1;
    cycle();
    clr_in();
    check_eq("exc_valid", pv, 1);
    check_eq("exc_fmt", fmt, F_SYNC);
    check_eq("exc_sub", sub, SF_EXCEPTION);
    pop();
    check_eq("exc_single", pv, 0);

    // Five requests into a stalled 4-deep FIFO
    do_flush();
    check_eq("flush_ovf", ovf, 0);
    for (int i = 0; i < 5; i++) instr(0, 0, 1);
    check_eq("ovf_set", ovf, 1);
    check_eq("ovf_pend", pend, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("drain%0d_valid", i), pv, 1);
      check_eq($sformatf("drain%0d_fmt", i), fmt, F_ADDR_ONLY);
      pop();
    end
    check_eq("drain_empty", pv, 0);
    check_eq("ovf_sticky", ovf, 1);
    instr(0, 0, 0);
    check_eq("resync_fmt", fmt, F_SYNC);
    check_eq("resync_sub", sub, SF_START);
    check_eq("resync_pend_clr", pend, 0);
    pop();

    // Periodic resync on the RESYNC_MAX=8 instance
    do_flush();
    for (int i = 0; i < 7; i++) instr(0, 0, 0);
    check_eq("rs7_pend", pend_r, 0);
    instr(0, 0, 0);
    check_eq("rs8_pend", pend_r, 1);
    check_eq("rs8_valid", pv_r, 0);
    instr(0, 0, 0);
    check_eq("rs9_valid", pv_r, 1);
    check_eq("rs9_fmt", fmt_r, F_SYNC);
    check_eq("rs9_sub", sub_r, SF_START);
    check_eq("rs9_pend", pend_r, 0);

    // Push and pop together while full, then a real drop, then async reset
    do_flush();
    for (int i = 0; i < 4; i++) instr(0, 0, 1);
    ready = 1;
    instr(0, 0, 1);
    ready = 0;
    check_eq("pushpop_ovf", ovf, 0);
    check_eq("pushpop_valid", pv, 1);
    instr(0, 0, 1);
    check_eq("drop_ovf", ovf, 1);
    pop(); pop();
    check_eq("two_left", pv, 1);
    #2 rst = 1;
    #1;
    check_eq("async_valid", pv, 0);
    check_eq("async_ovf", ovf, 0);
    cycle();
    rst = 0;
    cycle();
    check_eq("post_rst_valid", pv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
